// File: rtl/iir_lowpass_mc.sv
// Multi-channel first-order IIR low-pass, y += alpha*(x - y), one shared multiplier, one channel per cycle.
// Optional high-pass residual output on hp_data when IIR_LPF_HPF_OUT_EN is defined.
module iir_lowpass_mc #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int COEF_W = 8
) (
    input  logic                     AUDIO_CLK,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [COEF_W-1:0]        coef,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data
`ifdef IIR_LPF_HPF_OUT_EN
    ,
    output logic [NUM_CH*DATA_W-1:0] hp_data
`endif
);

    localparam int LANE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int K_W    = $clog2(NUM_CH + 1);
    localparam int P_W    = DATA_W + COEF_W + 2;
    localparam logic [K_W-1:0]        K_LAST = K_W'(NUM_CH);
    localparam logic signed [P_W-1:0] RND    = P_W'(1) << (COEF_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t                     state_reg;
    logic [K_W-1:0]             k_reg;
    logic [NUM_CH*DATA_W-1:0]   x_reg;
    logic [COEF_W-1:0]          coef_reg;
    logic                       out_valid_reg;

    // History lives in a RAM; clear/reset invalidate it through per-channel valid bits.
    logic signed [DATA_W-1:0]   y_mem [NUM_CH];
    logic [NUM_CH-1:0]          hist_vld_reg;
    logic signed [DATA_W-1:0]   y_rd_reg;
    logic                       y_vld_reg;
    logic                       rd_en_reg;
    logic [LANE_W-1:0]          rd_lane_reg;

    logic signed [DATA_W-1:0]   out_lane_reg [NUM_CH];
    logic signed [DATA_W-1:0]   x_lane [NUM_CH];

    logic signed [DATA_W-1:0]   y_cur;
    logic signed [DATA_W-1:0]   x_cur;
    logic signed [DATA_W:0]     d;
    logic signed [P_W-1:0]      p;
    logic signed [P_W-1:0]      p_rnd;
    logic signed [DATA_W-1:0]   y_new;

    // Channel 0 occupies the most significant lane.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            assign x_lane[gi] = x_reg[(NUM_CH-1-gi)*DATA_W +: DATA_W];
            assign out_data[(NUM_CH-1-gi)*DATA_W +: DATA_W] = out_lane_reg[gi];
        end
    endgenerate

    assign in_ready  = (state_reg == IDLE) && !clear;
    assign out_valid = out_valid_reg;

    always_comb begin
        y_cur = y_vld_reg ? y_rd_reg : '0;
        x_cur = x_lane[rd_lane_reg];
        d     = {x_cur[DATA_W-1], x_cur} - {y_cur[DATA_W-1], y_cur};
        p     = d * $signed({1'b0, coef_reg});
        p_rnd = p + RND;
        // Result lies between y and x, so dropping the upper bits never wraps.
        y_new = DATA_W'((p_rnd >>> COEF_W) + P_W'(y_cur));
    end

`ifdef IIR_LPF_HPF_OUT_EN
    localparam logic signed [DATA_W-1:0] HP_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] HP_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] hp_sat;
    logic signed [DATA_W-1:0] hp_lane_reg [NUM_CH];

    always_comb begin
        hp_sat = d[DATA_W-1:0];
        if (d[DATA_W] != d[DATA_W-1]) begin
            hp_sat = d[DATA_W] ? HP_MIN : HP_MAX;
        end
    end

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_hp_lane
            assign hp_data[(NUM_CH-1-gi)*DATA_W +: DATA_W] = hp_lane_reg[gi];
        end
    endgenerate

    always_ff @(posedge AUDIO_CLK) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hp_lane_reg[i] <= '0;
            end
        end else if (!clear && rd_en_reg) begin
            hp_lane_reg[rd_lane_reg] <= hp_sat;
        end
    end
`endif

    always_ff @(posedge AUDIO_CLK) begin
        y_rd_reg <= y_mem[k_reg[LANE_W-1:0]];
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (!rst && !clear && rd_en_reg) begin
            y_mem[rd_lane_reg] <= y_new;
        end
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (rst || clear) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            out_valid_reg <= 1'b0;
            hist_vld_reg  <= '0;
            rd_en_reg     <= 1'b0;
            y_vld_reg     <= 1'b0;
            rd_lane_reg   <= '0;
            if (rst) begin
                x_reg    <= '0;
                coef_reg <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    out_lane_reg[i] <= '0;
                end
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= in_data;
                        coef_reg  <= coef;
                        k_reg     <= '0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    // Read of channel k overlaps the write-back of channel k-1.
                    if (k_reg < K_LAST) begin
                        rd_en_reg   <= 1'b1;
                        rd_lane_reg <= k_reg[LANE_W-1:0];
                        y_vld_reg   <= hist_vld_reg[k_reg[LANE_W-1:0]];
                    end else begin
                        rd_en_reg     <= 1'b0;
                        state_reg     <= HOLD;
                        out_valid_reg <= 1'b1;
                    end
                    k_reg <= k_reg + K_W'(1);
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (rd_en_reg) begin
                out_lane_reg[rd_lane_reg] <= y_new;
                hist_vld_reg[rd_lane_reg] <= 1'b1;
            end
        end
    end

endmodule
